// File: rtl/mac_col_pkg.sv
// Shared widths and instruction encoding for the attention MAC column.
package mac_col_pkg;

  localparam int unsigned BW      = 8;
  localparam int unsigned PR      = 8;
  localparam int unsigned BW_PSUM = 2 * BW + 6;

  localparam int unsigned INST_LOAD = 0;
  localparam int unsigned INST_EXEC = 1;

  localparam int unsigned      CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/mac_col_dot.sv
// Combinational signed dot product of two packed pr-element vectors.
module mac_dot
  import mac_col_pkg::*;
#(
  parameter int unsigned bw      = BW,
  parameter int unsigned pr      = PR,
  parameter int unsigned bw_psum = 2 * bw + 6
) (
  input  logic        [pr*bw-1:0]   key,
  input  logic        [pr*bw-1:0]   query,
  output logic signed [bw_psum-1:0] sum_c
);

  logic signed [2*bw-1:0]    k_ext;
  logic signed [2*bw-1:0]    q_ext;
  logic signed [2*bw-1:0]    prod;
  logic signed [bw_psum-1:0] acc;

  // Each lane is sign-extended before the multiply so the product is a full 2*bw result.
  always_comb begin
    k_ext = '0;
    q_ext = '0;
    prod  = '0;
    acc   = '0;
    for (int i = 0; i < int'(pr); i++) begin
      k_ext = (2*bw)'($signed(key[i*bw +: bw]));
      q_ext = (2*bw)'($signed(query[i*bw +: bw]));
      prod  = k_ext * q_ext;
      acc   = acc + bw_psum'(prod);
    end
    sum_c = acc;
  end

endmodule

// File: rtl/mac_col.sv
// One column of the attention MAC array: captures its key during load,
// then emits key . query for every execute beat and forwards query/inst downstream.
module mac_col
  import mac_col_pkg::*;
#(
  parameter int unsigned bw      = BW,
  parameter int unsigned bw_psum = 2 * bw + 6,
  parameter int unsigned pr      = PR,
  parameter int unsigned col_id  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic        [1:0]         i_inst,
  input  logic        [pr*bw-1:0]   q_in,
  output logic        [pr*bw-1:0]   q_out,
  output logic        [1:0]         o_inst,
  output logic signed [bw_psum-1:0] out,
  output logic                      fifo_wr
);

  logic [pr*bw-1:0]          query_q;
  logic [pr*bw-1:0]          key_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      load_ready;
  logic                      exec_q;
  logic signed [bw_psum-1:0] dot_c;
  logic                      is_exec;
  logic                      is_load;

  // 2'b11 counts as execute only, so load requires the exec bit clear.
  assign is_exec = i_inst[INST_EXEC];
  assign is_load = i_inst[INST_LOAD] && !i_inst[INST_EXEC];

  mac_dot #(
    .bw      (bw),
    .pr      (pr),
    .bw_psum (bw_psum)
  ) u_dot (
    .key   (key_q),
    .query (query_q),
    .sum_c (dot_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      query_q    <= '0;
      key_q      <= '0;
      cnt_q      <= '0;
      load_ready <= 1'b1;
      exec_q     <= 1'b0;
      out        <= '0;
      o_inst     <= '0;
      fifo_wr    <= 1'b0;
    end else begin
      o_inst  <= i_inst;
      exec_q  <= is_exec;
      fifo_wr <= exec_q;
      if (exec_q) begin
        out <= dot_c;
      end
      if (is_exec || is_load) begin
        query_q <= q_in;
      end
      // Load beats are counted until this column's beat arrives; the counter then freezes.
      if (is_load && load_ready) begin
        if (cnt_q == CNT_W'(col_id)) begin
          key_q      <= q_in;
          load_ready <= 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign q_out = query_q;

endmodule

// File: tb/tb_mac_col.sv
// Directed bench for mac_col: two columns (col_id 0 and 3) share one stimulus stream.
module tb_mac_col;

  logic               clk;
  logic               reset;
  logic        [1:0]  i_inst;
  logic        [63:0] q_in;
  logic        [63:0] q_out0, q_out3;
  logic        [1:0]  o_inst0, o_inst3;
  logic signed [21:0] out0, out3;
  logic               fw0, fw3;

  int n_chk;
  int n_pass;

  mac_col #(.bw(8), .bw_psum(22), .pr(8), .col_id(0)) dut0 (
    .clk(clk), .reset(reset), .i_inst(i_inst), .q_in(q_in),
    .q_out(q_out0), .o_inst(o_inst0), .out(out0), .fifo_wr(fw0)
  );

  mac_col #(.bw(8), .bw_psum(22), .pr(8), .col_id(3)) dut3 (
    .clk(clk), .reset(reset), .i_inst(i_inst), .q_in(q_in),
    .q_out(q_out3), .o_inst(o_inst3), .out(out3), .fifo_wr(fw3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  function automatic logic [63:0] ps(input logic signed [21:0] v);
    return {42'd0, v};
  endfunction

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick(input logic [1:0] inst, input logic [63:0] q);
    i_inst = inst;
    q_in   = q;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2'b00, 64'd0);
    tick(2'b00, 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    i_inst = 2'b00;
    q_in   = 64'd0;

    // Reset state
    do_reset();
    chk("rst_o_inst", 64'(o_inst0), 64'd0);
    chk("rst_q_out", q_out0, 64'd0);
    chk("rst_out", ps(out0), 64'd0);
    chk("rst_fifo_wr", 64'(fw0), 64'd0);
    tick(2'b10, rep(8'h01));
    tick(2'b00, 64'd0);
    chk("zero_key_out", ps(out0), 64'd0);
    chk("zero_key_wr", 64'(fw0), 64'd1);

    // col_id 0 takes the first load beat
    do_reset();
    tick(2'b01, rep(8'h01));
    for (int k = 0; k < 9; k++) tick(2'b01, {$urandom, $urandom});
    tick(2'b00, 64'd0);
    tick(2'b00, 64'd0);
    tick(2'b10, rep(8'h02));
    chk("basic_wr_early", 64'(fw0), 64'd0);
    tick(2'b00, 64'd0);
    chk("basic_out", ps(out0), 64'h10);
    chk("basic_wr", 64'(fw0), 64'd1);
    tick(2'b00, 64'd0);
    chk("basic_wr_drop", 64'(fw0), 64'd0);
    chk("basic_out_hold", ps(out0), 64'h10);

    // Signed arithmetic: -1 * 3 per lane
    do_reset();
    tick(2'b01, rep(8'hFF));
    tick(2'b10, rep(8'h03));
    tick(2'b00, 64'd0);
    chk("neg_out", ps(out0), 64'h3FFFE8);

    // Most negative operands: (-128)*(-128)*8
    do_reset();
    tick(2'b01, rep(8'h80));
    tick(2'b10, rep(8'h80));
    tick(2'b00, 64'd0);
    chk("minmin_out", ps(out0), 64'h020000);

    // col_id 3 captures beat 3 of V0..V9
    do_reset();
    for (int k = 0; k < 10; k++) tick(2'b01, rep(8'(k)));
    tick(2'b10, rep(8'h01));
    tick(2'b00, 64'd0);
    chk("col3_out", ps(out3), 64'd24);
    chk("col0_out", ps(out0), 64'd0);
    tick(2'b01, rep(8'h09));
    tick(2'b01, rep(8'h07));
    tick(2'b10, rep(8'h01));
    tick(2'b00, 64'd0);
    chk("col3_key_kept", ps(out3), 64'd24);

    // 2'b11 must neither count a load beat nor capture the key
    do_reset();
    tick(2'b11, rep(8'h05));
    tick(2'b11, rep(8'h06));
    for (int k = 0; k < 4; k++) tick(2'b01, rep(8'(k + 1)));
    tick(2'b10, rep(8'h01));
    tick(2'b00, 64'd0);
    chk("inst11_col3", ps(out3), 64'd32);
    chk("inst11_col0", ps(out0), 64'd8);

    // Pipeline pass-through
    do_reset();
    tick(2'b01, 64'h1111_2222_3333_4444);
    chk("pipe_inst0", 64'(o_inst0), 64'd1);
    chk("pipe_q0", q_out0, 64'h1111_2222_3333_4444);
    tick(2'b01, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("pipe_inst1", 64'(o_inst0), 64'd1);
    chk("pipe_q1", q_out0, 64'hAAAA_BBBB_CCCC_DDDD);
    tick(2'b00, 64'h0123_4567_89AB_CDEF);
    chk("pipe_inst2", 64'(o_inst0), 64'd0);
    chk("pipe_q2_hold", q_out0, 64'hAAAA_BBBB_CCCC_DDDD);
    tick(2'b10, 64'h5555_6666_7777_8888);
    chk("pipe_inst3", 64'(o_inst3), 64'd2);
    chk("pipe_q3", q_out3, 64'h5555_6666_7777_8888);
    tick(2'b00, 64'hFEDC_BA98_7654_3210);
    chk("pipe_inst4", 64'(o_inst0), 64'd0);
    chk("pipe_q4_hold", q_out0, 64'h5555_6666_7777_8888);

    // Back-to-back execute, key lanes 1..8
    do_reset();
    tick(2'b01, 64'h0807_0605_0403_0201);
    tick(2'b10, rep(8'h01));
    chk("b2b_wr0", 64'(fw0), 64'd0);
    tick(2'b10, rep(8'h02));
    chk("b2b_wr1", 64'(fw0), 64'd1);
    chk("b2b_out1", ps(out0), 64'd36);
    tick(2'b10, rep(8'hFF));
    chk("b2b_wr2", 64'(fw0), 64'd1);
    chk("b2b_out2", ps(out0), 64'd72);
    tick(2'b00, 64'd0);
    chk("b2b_wr3", 64'(fw0), 64'd1);
    chk("b2b_out3", ps(out0), 64'h3FFFDC);
    tick(2'b00, 64'd0);
    chk("b2b_wr_end", 64'(fw0), 64'd0);
    chk("b2b_out_hold", ps(out0), 64'h3FFFDC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
